// File: rtl/decode_stage_if.sv
// Bundle between fetch, write-back, hazard source and the decode stage;
// decode_stage takes the slave side, the driver of instructions the master side.
interface decode_stage_if;
  logic        flush;
  logic        EN_REG;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        alu_src;
  logic        illegal_instr;

  modport master (
    output flush, EN_REG, instruction, pc_in, wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  stall, pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7,
           reg_write, mem_read, mem_write, branch, alu_src, illegal_instr
  );

  modport slave (
    input  flush, EN_REG, instruction, pc_in, wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    output stall, pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7,
           reg_write, mem_read, mem_write, branch, alu_src, illegal_instr
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: field/immediate/control decode, 32x32 register
// file with write-through bypass, load-use stall and decode/execute register.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IALU   = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        illegal;
  } stage_t;

  logic [31:0] rf_q [32];
  stage_t      stage_d, stage_q;
  logic [31:0] instr;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        use_rs1, use_rs2;
  logic        is_nop;
  logic        stall;

  assign instr   = bus.instruction;
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign is_nop  = (instr == NOP_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Same-cycle write-back is bypassed so the decoded operand is never stale.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != 5'd0)
      rs1_val = (bus.wb_en && bus.wb_rd == rs1_idx) ? bus.wb_data : rf_q[rs1_idx];
    if (rs2_idx != 5'd0)
      rs2_val = (bus.wb_en && bus.wb_rd == rs2_idx) ? bus.wb_data : rf_q[rs2_idx];
  end

  always_comb begin
    stage_d          = '0;
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    stage_d.pc       = bus.pc_in;
    stage_d.rs1_data = rs1_val;
    stage_d.rs2_data = rs2_val;
    stage_d.rs1      = rs1_idx;
    stage_d.rs2      = rs2_idx;
    stage_d.rd       = instr[11:7];
    stage_d.funct3   = instr[14:12];
    stage_d.funct7   = instr[31:25];
    case (instr[6:0])
      OP_R: begin
        stage_d.reg_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IALU: begin
        stage_d.reg_write = 1'b1;
        stage_d.alu_src   = 1'b1;
        stage_d.imm       = {{20{instr[31]}}, instr[31:20]};
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        stage_d.reg_write = 1'b1;
        stage_d.mem_read  = 1'b1;
        stage_d.alu_src   = 1'b1;
        stage_d.imm       = {{20{instr[31]}}, instr[31:20]};
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        stage_d.mem_write = 1'b1;
        stage_d.alu_src   = 1'b1;
        stage_d.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        stage_d.branch = 1'b1;
        stage_d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: stage_d.illegal = 1'b1;
    endcase
  end

  // The NOP term is redundant for the default encoding (rs1=x0 never matches)
  // but keeps an overridden bubble encoding from ever stalling fetch.
  assign stall = ~reset & ~bus.flush & ~is_nop & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                 ((use_rs1 & (bus.ex_rd == rs1_idx)) | (use_rs2 & (bus.ex_rd == rs2_idx)));

  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall) stage_q <= '0;
    else if (bus.EN_REG)              stage_q <= stage_d;
  end

  assign bus.stall         = stall;
  assign bus.pc_out        = stage_q.pc;
  assign bus.rs1_data      = stage_q.rs1_data;
  assign bus.rs2_data      = stage_q.rs2_data;
  assign bus.imm           = stage_q.imm;
  assign bus.rs1           = stage_q.rs1;
  assign bus.rs2           = stage_q.rs2;
  assign bus.rd            = stage_q.rd;
  assign bus.funct3        = stage_q.funct3;
  assign bus.funct7        = stage_q.funct7;
  assign bus.reg_write     = stage_q.reg_write;
  assign bus.mem_read      = stage_q.mem_read;
  assign bus.mem_write     = stage_q.mem_write;
  assign bus.branch        = stage_q.branch;
  assign bus.alu_src       = stage_q.alu_src;
  assign bus.illegal_instr = stage_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  decode_stage_if bus();

  decode_stage #(.NOP_INSTR(32'h00000013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ADD_3_5_0  = 32'h000281B3;
  localparam logic [31:0] LW_1_M4_2  = 32'hFFC12083;
  localparam logic [31:0] SW_1_8_2   = 32'h00112423;
  localparam logic [31:0] ADD_4_1_2  = 32'h00208233;
  localparam logic [31:0] ADDI_6_2_1 = 32'h00110313;
  localparam logic [31:0] ADDI_1_0_0 = 32'h00000093;
  localparam logic [31:0] ADDI_1_7_0 = 32'h00038093;
  localparam logic [31:0] ILLEGAL    = 32'h0000007F;
  localparam logic [31:0] BEQ_1_2_M8 = 32'hFE208CE3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl();
    return {26'd0, bus.illegal_instr, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.alu_src};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    bus.instruction = ins;
    bus.pc_in       = pc;
  endtask

  initial begin
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.EN_REG      = 1'b1;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd1;
    drive(ADD_4_1_2, 32'h44);
    #1;
    chk("stall_in_reset", {31'd0, bus.stall}, 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hAAAA5555;
    tick();
    tick();
    chk("rst_pc", bus.pc_out, 32'd0);
    chk("rst_ctrl", ctrl(), 32'd0);
    chk("rst_rs1_data", bus.rs1_data, 32'd0);
    chk("rst_rd", {27'd0, bus.rd}, 32'd0);

    reset = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h12345678;
    drive(NOP, 32'h0);
    tick();
    chk("nop_ctrl", ctrl(), 32'b010001);
    chk("nop_rd", {27'd0, bus.rd}, 32'd0);
    bus.wb_en = 1'b0;
    drive(ADD_3_5_0, 32'h100);
    tick();
    chk("add_ctrl", ctrl(), 32'b010000);
    chk("add_rs1_data", bus.rs1_data, 32'h12345678);
    chk("add_rs2_data", bus.rs2_data, 32'd0);
    chk("add_rd", {27'd0, bus.rd}, 32'd3);
    chk("add_pc", bus.pc_out, 32'h100);
    chk("add_imm", bus.imm, 32'd0);

    drive(LW_1_M4_2, 32'h104);
    tick();
    chk("lw_ctrl", ctrl(), 32'b011001);
    chk("lw_imm", bus.imm, 32'hFFFFFFFC);
    chk("lw_rd", {27'd0, bus.rd}, 32'd1);
    chk("lw_f3", {29'd0, bus.funct3}, 32'd2);

    drive(SW_1_8_2, 32'h108);
    tick();
    chk("sw_ctrl", ctrl(), 32'b000101);
    chk("sw_imm", bus.imm, 32'd8);
    chk("sw_rs2", {27'd0, bus.rs2}, 32'd1);

    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
    drive(ADD_4_1_2, 32'h10C);
    #1;
    chk("hz_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("hz_bubble_ctrl", ctrl(), 32'd0);
    chk("hz_bubble_pc", bus.pc_out, 32'd0);
    bus.ex_rd = 5'd2;
    #1;
    chk("hz_rs2_stall", {31'd0, bus.stall}, 32'd1);
    bus.ex_rd = 5'd0;
    #1;
    chk("hz_x0_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("hz_x0_ctrl", ctrl(), 32'b010000);
    chk("hz_x0_rd", {27'd0, bus.rd}, 32'd4);

    // addi rs2 field holds imm bit pattern 1; it must not count as a use
    bus.ex_rd = 5'd1;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hDEADBEEF;
    drive(ADDI_6_2_1, 32'h110);
    #1;
    chk("addi_no_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
    bus.wb_en = 1'b0;
    chk("byp_rs1_data", bus.rs1_data, 32'hDEADBEEF);
    chk("byp_imm", bus.imm, 32'd1);
    chk("byp_rd", {27'd0, bus.rd}, 32'd6);
    tick();
    chk("wr_rs1_data", bus.rs1_data, 32'hDEADBEEF);

    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    drive(ADDI_1_0_0, 32'h114);
    tick();
    chk("x0_byp", bus.rs1_data, 32'd0);
    bus.wb_en = 1'b0;
    tick();
    chk("x0_read", bus.rs1_data, 32'd0);
    drive(ADDI_1_7_0, 32'h118);
    tick();
    chk("x7_reset_write_dropped", bus.rs1_data, 32'd0);

    drive(ADD_3_5_0, 32'h200);
    tick();
    bus.EN_REG = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(LW_1_M4_2, 32'h300);
        1: drive(SW_1_8_2, 32'h304);
        default: drive(BEQ_1_2_M8, 32'h308);
      endcase
      tick();
      chk("hold_pc", bus.pc_out, 32'h200);
      chk("hold_ctrl", ctrl(), 32'b010000);
      chk("hold_rd", {27'd0, bus.rd}, 32'd3);
    end
    bus.EN_REG = 1'b1;

    bus.flush = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
    drive(ADD_4_1_2, 32'h400);
    #1;
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("flush_ctrl", ctrl(), 32'd0);
    chk("flush_pc", bus.pc_out, 32'd0);
    bus.flush = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;

    drive(ILLEGAL, 32'h404);
    tick();
    chk("ill_ctrl", ctrl(), 32'b100000);
    chk("ill_imm", bus.imm, 32'd0);

    drive(BEQ_1_2_M8, 32'h408);
    tick();
    chk("beq_ctrl", ctrl(), 32'b000010);
    chk("beq_imm", bus.imm, 32'hFFFFFFF8);
    chk("beq_rs1", {27'd0, bus.rs1}, 32'd1);
    chk("beq_rs2", {27'd0, bus.rs2}, 32'd2);

    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    drive(ADD_3_5_0, 32'h500);
    #1;
    chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("mid_rst_ctrl", ctrl(), 32'd0);
    chk("mid_rst_pc", bus.pc_out, 32'd0);
    reset = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
    tick();
    chk("post_rst_x5", bus.rs1_data, 32'd0);
    chk("post_rst_ctrl", ctrl(), 32'b010000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
